// File: rtl/rr_grant_encoder_if.sv
// Bus between a 4-way requester group and the round-robin grant encoder.
// The encoder drives the grant, the decoder select (B,A) and an observation view of its FSM.
interface rr_grant_encoder_if;
   logic [3:0] req;
   logic       done;
   logic       grant_valid;
   logic       B;
   logic       A;
   logic       expired;
   logic       dbg_state;
   logic [1:0] dbg_ptr;
   logic [7:0] dbg_hold_cnt;

   // Requesters raise req[i] and hold it while they want or own grant i; done ends ownership.
   // A grant is live while grant_valid=1 and {B,A} names the owner; no ready back-pressure.
   modport master (
      output req,
      output done,
      input  grant_valid,
      input  B,
      input  A,
      input  expired,
      input  dbg_state,
      input  dbg_ptr,
      input  dbg_hold_cnt
   );

   modport slave (
      input  req,
      input  done,
      output grant_valid,
      output B,
      output A,
      output expired,
      output dbg_state,
      output dbg_ptr,
      output dbg_hold_cnt
   );
endinterface

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 4 requests that encodes the winner onto a 2-bit decoder select.
// Grants are held until done, request drop or a MAX_HOLD-cycle timeout; all outputs registered.
module rr_grant_encoder #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   rr_grant_encoder_if.slave   bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [0:0] state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       grant_valid_q, grant_valid_d;
   logic [1:0] idx_q, idx_d;
   logic       expired_q, expired_d;

   logic [1:0] pick_idx;
   logic [1:0] cand;
   logic       owner_req;
   logic       timeout;
   logic       release_now;

   // Scan from the farthest offset down so the closest set bit to ptr wins.
   always_comb begin
      pick_idx = ptr_q;
      cand     = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (bus.req[cand]) begin
            pick_idx = cand;
         end
      end
   end

   assign owner_req   = bus.req[idx_q];
   assign timeout     = (hold_cnt_q == HOLD_LAST);
   assign release_now = bus.done || !owner_req || timeout;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      hold_cnt_d    = hold_cnt_q;
      grant_valid_d = grant_valid_q;
      idx_d         = idx_q;
      expired_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req != 4'b0000) begin
               state_d       = GRANT;
               grant_valid_d = 1'b1;
               idx_d         = pick_idx;
               hold_cnt_d    = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               ptr_d         = idx_q + 2'd1;
               hold_cnt_d    = 8'd0;
               // A timeout only counts when neither done nor the drop explains the release.
               expired_d     = timeout && !bus.done && owner_req;
            end else begin
               hold_cnt_d    = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= 2'd0;
         hold_cnt_q    <= 8'd0;
         grant_valid_q <= 1'b0;
         idx_q         <= 2'd0;
         expired_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         grant_valid_q <= grant_valid_d;
         idx_q         <= idx_d;
         expired_q     <= expired_d;
      end
   end

   assign bus.grant_valid  = grant_valid_q;
   assign bus.B            = idx_q[1];
   assign bus.A            = idx_q[0];
   assign bus.expired      = expired_q;
   assign bus.dbg_state    = state_q;
   assign bus.dbg_ptr      = ptr_q;
   assign bus.dbg_hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder with hand-computed expected grants, pulses and pointer.
module tb_rr_grant_encoder;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   rr_grant_encoder_if bus ();

   rr_grant_encoder #(.MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic gv, input logic [1:0] ba,
                             input logic ex);
      check_val({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(gv));
      check_val({tag, ".BA"}, 32'({bus.B, bus.A}), 32'(ba));
      check_val({tag, ".expired"}, 32'(bus.expired), 32'(ex));
   endtask

   // Advance one edge and settle so checks see the registered values.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;

      // Reset with everything asserted must win.
      rst_n = 1'b0; bus.req = 4'b1111; bus.done = 1'b1;
      tick(); expect_out("rst0", 1'b0, 2'd0, 1'b0);
      tick(); expect_out("rst1", 1'b0, 2'd0, 1'b0);
      check_val("rst.ptr", 32'(bus.dbg_ptr), 32'd0);

      // Single request, released by done; select stays on 2.
      rst_n = 1'b1; bus.req = 4'b0100; bus.done = 1'b0;
      tick(); expect_out("single.grant", 1'b1, 2'd2, 1'b0);
      bus.done = 1'b1;
      tick(); expect_out("single.rel", 1'b0, 2'd2, 1'b0);
      bus.done = 1'b0; bus.req = 4'b0000;
      tick(); expect_out("single.idle", 1'b0, 2'd2, 1'b0);
      check_val("single.ptr", 32'(bus.dbg_ptr), 32'd3);

      // Rotation with all requests; done held high also checks it is ignored in IDLE.
      rst_n = 1'b0;
      tick(); expect_out("rot.rst", 1'b0, 2'd0, 1'b0);
      rst_n = 1'b1; bus.req = 4'b1111; bus.done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); expect_out($sformatf("rot%0d.grant", i), 1'b1, 2'(i % 4), 1'b0);
         tick(); expect_out($sformatf("rot%0d.gap", i), 1'b0, 2'(i % 4), 1'b0);
      end
      check_val("rot.ptr", 32'(bus.dbg_ptr), 32'd1);

      // Timeout: req=0010 held for MAX_HOLD=8 cycles, then expired pulse, then regrant.
      bus.done = 1'b0; bus.req = 4'b0010;
      tick(); expect_out("to.grant", 1'b1, 2'd1, 1'b0);
      for (int i = 1; i < 8; i++) begin
         tick(); expect_out($sformatf("to.hold%0d", i), 1'b1, 2'd1, 1'b0);
      end
      tick(); expect_out("to.expire", 1'b0, 2'd1, 1'b1);
      tick(); expect_out("to.regrant", 1'b1, 2'd1, 1'b0);
      bus.req = 4'b0000;
      tick(); expect_out("to.drop", 1'b0, 2'd1, 1'b0);

      // Timeout coinciding with done must not flag expired.
      bus.req = 4'b0010;
      tick(); expect_out("tod.grant", 1'b1, 2'd1, 1'b0);
      for (int i = 1; i < 8; i++) begin
         tick();
      end
      check_val("tod.hold_cnt", 32'(bus.dbg_hold_cnt), 32'd7);
      bus.done = 1'b1;
      tick(); expect_out("tod.rel", 1'b0, 2'd1, 1'b0);
      bus.done = 1'b0; bus.req = 4'b0000;
      tick(); expect_out("tod.idle", 1'b0, 2'd1, 1'b0);

      // Request drop at hold_cnt=3 wraps ptr from 3 to 0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; bus.req = 4'b1000;
      tick(); expect_out("drop.grant", 1'b1, 2'd3, 1'b0);
      tick(); tick(); tick();
      check_val("drop.hold_cnt", 32'(bus.dbg_hold_cnt), 32'd3);
      bus.req = 4'b0000;
      tick(); expect_out("drop.rel", 1'b0, 2'd3, 1'b0);
      check_val("drop.ptr", 32'(bus.dbg_ptr), 32'd0);
      bus.req = 4'b0011;
      tick(); expect_out("drop.next", 1'b1, 2'd0, 1'b0);
      bus.req = 4'b0000;
      tick(); expect_out("drop.end", 1'b0, 2'd0, 1'b0);

      // Reset during a grant of index 2 drops it; next grant restarts at 0.
      bus.req = 4'b1111;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); expect_out("mid.g0", 1'b1, 2'd0, 1'b0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick(); expect_out("mid.g1", 1'b1, 2'd1, 1'b0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick(); expect_out("mid.g2", 1'b1, 2'd2, 1'b0);
      rst_n = 1'b0;
      tick(); expect_out("mid.rst", 1'b0, 2'd0, 1'b0);
      check_val("mid.ptr", 32'(bus.dbg_ptr), 32'd0);
      rst_n = 1'b1;
      tick(); expect_out("mid.after", 1'b1, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
